// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I data-memory controller: strobe/ack bus master with load formatting and timeout
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and complete with o_err.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic        i_we,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_busy,
    output logic        o_mem_stb,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_sel,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic        misalign;
    logic        timeout_hit;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Request-side lane formatting; reserved funct3 codes fall into the word case
    always_comb begin
        req_sel   = 4'b1111;
        req_wdata = i_wdata;
        misalign  = 1'b0;
        case (i_funct3)
            3'b000, 3'b100: begin
                req_sel   = 4'b0001 << i_addr[1:0];
                req_wdata = {4{i_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                req_sel   = 4'b0011 << {i_addr[1], 1'b0};
                req_wdata = {2{i_wdata[15:0]}};
`ifdef MISALIGN_TRAP_EN
                misalign  = i_addr[0];
`endif
            end
            default: begin
`ifdef MISALIGN_TRAP_EN
                misalign  = (i_addr[1:0] != 2'b00);
`endif
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            funct3_q <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    // A trapped access spends its BUS cycle with the strobe suppressed, keeping the 2-cycle latency
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req) state_d = BUS;
            BUS:     if (err_q || i_mem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        sel_d    = sel_q;
        we_d     = we_q;
        err_d    = err_q;
        if (state_q == IDLE && i_req) begin
            addr_d   = {i_addr[31:2], 2'b00};
            funct3_d = i_funct3;
            we_d     = i_we;
            wdata_d  = req_wdata;
            sel_d    = req_sel;
            err_d    = misalign;
            rdata_d  = '0;
            cnt_d    = '0;
            if (i_funct3[1:0] != 2'b10 && i_funct3[1:0] != 2'b11) addr_d[1:0] = i_addr[1:0];
        end else if (state_q == BUS && !err_q) begin
            if (i_mem_ack) rdata_d = i_mem_rdata;
            else if (timeout_hit) err_d = 1'b1;
            else cnt_d = cnt_q + 32'd1;
        end
    end

    always_comb begin
        ld_byte = rdata_q[8*addr_q[1:0] +: 8];
        ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    always_comb begin
        o_ack       = (state_q == DONE);
        o_err       = o_ack && err_q;
        o_busy      = (state_q != IDLE);
        o_rdata     = (o_ack && !we_q && !err_q) ? ld_data : 32'd0;
        o_mem_stb   = (state_q == BUS) && !err_q;
        o_mem_we    = o_mem_stb && we_q;
        o_mem_addr  = o_mem_stb ? {addr_q[31:2], 2'b00} : 32'd0;
        o_mem_wdata = o_mem_stb ? wdata_q : 32'd0;
        o_mem_sel   = o_mem_stb ? sel_q : 4'd0;
    end
endmodule
